// File: rtl/div_fixedpoint_hs_pkg.sv
// div_pkg: shared state encoding and width helpers for the div_fixedpoint_hs divider.
package div_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   function automatic int qw(input int width, input int frac);
      return width + frac;
   endfunction
   function automatic int cnt_w(input int width, input int frac);
      return $clog2(width + frac + 1);
   endfunction
endpackage

// File: rtl/div_fixedpoint_hs_if.sv
// div_fixedpoint_hs_if: operand and result handshake bundle of div_fixedpoint_hs.
interface div_fixedpoint_hs_if #(parameter int WIDTH = 48, parameter int FRAC = 16, parameter int TAG_W = 4);
   import div_pkg::*;
   localparam int QW = qw(WIDTH, FRAC);
   logic in_valid_i, in_ready_o, out_valid_o, out_ready_i, dz_o, ovf_o;
   logic [WIDTH-1:0] n_i, d_i, r_o;
   logic [TAG_W-1:0] tag_i, tag_o;
   logic [QW-1:0] q_o;
   modport slave (input in_valid_i, n_i, d_i, tag_i, out_ready_i,
                  output in_ready_o, out_valid_o, q_o, r_o, tag_o, dz_o, ovf_o);
   modport master (output in_valid_i, n_i, d_i, tag_i, out_ready_i,
                   input in_ready_o, out_valid_o, q_o, r_o, tag_o, dz_o, ovf_o);
endinterface

// File: rtl/div_fixedpoint_hs_step.sv
// div_step: one restoring division iteration on a WIDTH+1 bit shifted partial remainder.
module div_step #(parameter int WIDTH = 48) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_bit_o
);
   logic [WIDTH:0] sh;
   always_comb begin
      sh = {rem_i, bit_i};
      q_bit_o = sh >= {1'b0, d_i};
      rem_o = q_bit_o ? WIDTH'(sh - {1'b0, d_i}) : sh[WIDTH-1:0];
   end
endmodule

// File: rtl/div_fixedpoint_hs.sv
// div_fixedpoint_hs: iterative radix-2 restoring fixed-point divider, q = (n << FRAC) / d, with handshakes.
// Define DIV_FIXEDPOINT_SIGNED_EN for two's complement operands with saturation and one extra fix-up cycle.
module div_fixedpoint_hs
   import div_pkg::*;
#(
   parameter int WIDTH = 48,
   parameter int FRAC  = 16,
   parameter int TAG_W = 4
) (
   input logic clk_i,
   input logic rst_n_i,
   div_fixedpoint_hs_if.slave bus
);
   localparam int QW = qw(WIDTH, FRAC);
   localparam int CW = cnt_w(WIDTH, FRAC);
`ifdef DIV_FIXEDPOINT_SIGNED_EN
   localparam logic [CW-1:0] FIX = CW'(1);
   localparam logic [QW-1:0] MIN = {1'b1, {(QW-1){1'b0}}};
   logic sn_q, sn_d, neg_q, neg_d, sat;
`else
   localparam logic [CW-1:0] FIX = '0;
`endif
   state_t state_q, state_d;
   logic [1:0] sync_q;
   logic rst_n, q_bit;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [QW-1:0] dvd_q, dvd_d, q_q, q_d;
   logic [WIDTH-1:0] rem_q, rem_d, den_q, den_d, r_q, r_d, rem_nx, r_mag, n_mag, d_mag;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic dz_q, dz_d, ovf_q, ovf_d, vld_q, vld_d;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) sync_q <= '0;
      else sync_q <= {sync_q[0], 1'b1};
   end
   assign rst_n = sync_q[1];

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i(rem_q), .d_i(den_q), .bit_i(dvd_q[QW-1]), .rem_o(rem_nx), .q_bit_o(q_bit)
   );

   // dvd_q shifts dividend bits out of the top while quotient bits fill in from the bottom
`ifdef DIV_FIXEDPOINT_SIGNED_EN
   assign n_mag = bus.n_i[WIDTH-1] ? WIDTH'(-bus.n_i) : bus.n_i;
   assign d_mag = bus.d_i[WIDTH-1] ? WIDTH'(-bus.d_i) : bus.d_i;
   assign sat = neg_q ? (dvd_q > MIN) : dvd_q[QW-1];
`else
   assign n_mag = bus.n_i;
   assign d_mag = bus.d_i;
`endif
   assign r_mag = dz_q ? dvd_q[QW-1 -: WIDTH] : rem_q;

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      dvd_d = dvd_q;
      rem_d = rem_q;
      den_d = den_q;
      tag_d = tag_q;
      dz_d = dz_q;
      q_d = q_q;
      r_d = r_q;
      ovf_d = ovf_q;
      vld_d = vld_q;
`ifdef DIV_FIXEDPOINT_SIGNED_EN
      sn_d = sn_q;
      neg_d = neg_q;
`endif
      if (state_q == IDLE && bus.in_valid_i) begin
         dvd_d = QW'(n_mag) << FRAC;
         den_d = d_mag;
         rem_d = '0;
         tag_d = bus.tag_i;
         dz_d = bus.d_i == '0;
`ifdef DIV_FIXEDPOINT_SIGNED_EN
         sn_d = bus.n_i[WIDTH-1];
         neg_d = bus.n_i[WIDTH-1] ^ bus.d_i[WIDTH-1];
`endif
         // divide-by-zero still waits one settle cycle in DONE before presenting
         cnt_d = dz_d ? CW'(1) + FIX : CW'(QW);
         state_d = dz_d ? DONE : CALC;
      end
      if (state_q == CALC) begin
         dvd_d = {dvd_q[QW-2:0], q_bit};
         rem_d = rem_nx;
         cnt_d = cnt_q == 1 ? FIX : cnt_q - CW'(1);
         state_d = cnt_q == 1 ? DONE : CALC;
      end
      if (state_q == DONE) begin
         if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
         else if (!vld_q) begin
            vld_d = 1'b1;
`ifdef DIV_FIXEDPOINT_SIGNED_EN
            r_d = sn_q ? WIDTH'(-r_mag) : r_mag;
            q_d = dz_q ? (sn_q ? MIN : ~MIN) : sat ? (neg_q ? MIN : ~MIN) : neg_q ? QW'(-dvd_q) : dvd_q;
            ovf_d = !dz_q && sat;
`else
            r_d = r_mag;
            q_d = dz_q ? '1 : dvd_q;
`endif
         end else if (bus.out_ready_i) begin
            vld_d = 1'b0;
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         dvd_q <= '0;
         rem_q <= '0;
         den_q <= '0;
         tag_q <= '0;
         dz_q <= 1'b0;
         q_q <= '0;
         r_q <= '0;
         ovf_q <= 1'b0;
         vld_q <= 1'b0;
`ifdef DIV_FIXEDPOINT_SIGNED_EN
         sn_q <= 1'b0;
         neg_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         dvd_q <= dvd_d;
         rem_q <= rem_d;
         den_q <= den_d;
         tag_q <= tag_d;
         dz_q <= dz_d;
         q_q <= q_d;
         r_q <= r_d;
         ovf_q <= ovf_d;
         vld_q <= vld_d;
`ifdef DIV_FIXEDPOINT_SIGNED_EN
         sn_q <= sn_d;
         neg_q <= neg_d;
`endif
      end
   end

   assign bus.in_ready_o = state_q == IDLE;
   assign bus.out_valid_o = vld_q;
   assign bus.q_o = q_q;
   assign bus.r_o = r_q;
   assign bus.tag_o = tag_q;
   assign bus.dz_o = dz_q;
   assign bus.ovf_o = ovf_q;
endmodule
